dram_responder: RTL

Synthesizable memory-side responder for the 16-lane byte-wide DRAM request interface driven by `top_level`. Each lane independently accepts a read or write request per cycle and returns a one-cycle `valid` pulse, with read data or write acknowledge, after a fixed pipeline latency. It replaces the behavioural DRAM model in the top-level bench and serves as the reference memory for lane-level verification.

---
 rtl/dram_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/dram_responder.sv
// Multi-lane byte-wide DRAM responder: shared byte array, per-lane fixed-latency
// response pipeline, sticky protocol-error flag.
module dram_responder #(
  parameter int LANES     = 16,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES-1:0]      en,
  input  logic [1:0]            rdwr,
  input  logic [LANES*64-1:0]   addr,
  input  logic [LANES*8-1:0]    data_in,
  output logic [LANES*8-1:0]    data_out,
  output logic [LANES-1:0]      valid,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]       mem [DEPTH];
  logic [LANES-1:0] addr_ok;
  logic [LANES-1:0] accept;
  logic             bad_req;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_addr_chk
    assign addr_ok[gi] = (addr[gi*64+ADDR_BITS +: 64-ADDR_BITS] == '0);
  end

  assign accept  = en & addr_ok & {LANES{~rdwr[1]}};
  assign bad_req = |(en & ~accept);

  // Ascending lane loop: the highest colliding lane's write lands last and wins.
  always_ff @(posedge clk) begin
    if (!reset && rdwr == 2'b01) begin
      for (int i = 0; i < LANES; i++) begin
        if (accept[i]) begin
          mem[addr[i*64 +: ADDR_BITS]] <= data_in[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (bad_req) begin
      err <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic       v_pipe [LATENCY];
    logic       r_pipe [LATENCY];
    logic [7:0] d_pipe [LATENCY];

    // Write acks and idle stages carry zero data so the output stage needs no masking.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < LATENCY; k++) begin
          v_pipe[k] <= 1'b0;
          r_pipe[k] <= 1'b0;
          d_pipe[k] <= 8'h00;
        end
      end else begin
        v_pipe[0] <= accept[gi];
        r_pipe[0] <= accept[gi] && !rdwr[0];
        d_pipe[0] <= (accept[gi] && !rdwr[0]) ? mem[addr[gi*64 +: ADDR_BITS]] : 8'h00;
        for (int k = 1; k < LATENCY; k++) begin
          v_pipe[k] <= v_pipe[k-1];
          r_pipe[k] <= r_pipe[k-1];
          d_pipe[k] <= d_pipe[k-1];
        end
      end
    end

    assign valid[gi]            = v_pipe[LATENCY-1];
    assign data_out[gi*8 +: 8]  = r_pipe[LATENCY-1] ? d_pipe[LATENCY-1] : 8'h00;
  end

endmodule
